// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer: optional dirty-victim writeback, line refill,
// then a one-cycle block write into the dcache before the access replays.
module dcache_miss_ctrl #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_mem_access,
    input  logic                   i_dcache_hit,
    input  logic                   i_dcache_dirty,
    input  logic [ADDR_WIDTH-1:0]  i_mem_addr,
    input  logic [ADDR_WIDTH-1:0]  i_wb_addr,
    input  logic [BLOCK_WIDTH-1:0] i_victim_block,
    input  logic                   i_axi_done,
    input  logic [BLOCK_WIDTH-1:0] i_axi_rdata,
    output logic                   o_axi_req,
    output logic                   o_axi_we,
    output logic [ADDR_WIDTH-1:0]  o_axi_addr,
    output logic [BLOCK_WIDTH-1:0] o_axi_wdata,
    output logic                   o_block_we,
    output logic [BLOCK_WIDTH-1:0] o_data_block,
    output logic                   o_stall,
    output logic [CNT_WIDTH-1:0]   o_miss_count,
    output logic [CNT_WIDTH-1:0]   o_wb_count
);

    localparam int                    OFFSET_BITS = $clog2(BLOCK_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK   = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_REFILL    = 2'd2;
    localparam logic [1:0] S_ALLOCATE  = 2'd3;

    logic [1:0]             r_state;
    logic                   r_axi_req;
    logic                   r_axi_we;
    logic [ADDR_WIDTH-1:0]  r_axi_addr;
    logic [ADDR_WIDTH-1:0]  r_refill_addr;
    logic [BLOCK_WIDTH-1:0] r_axi_wdata;
    logic                   r_block_we;
    logic [BLOCK_WIDTH-1:0] r_data_block;
    logic [CNT_WIDTH-1:0]   r_miss_count;
    logic [CNT_WIDTH-1:0]   r_wb_count;
    logic                   w_miss;

    assign w_miss  = i_mem_access & ~i_dcache_hit;
    assign o_stall = w_miss | (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state       <= S_IDLE;
            r_axi_req     <= 1'b0;
            r_axi_we      <= 1'b0;
            r_axi_addr    <= '0;
            r_refill_addr <= '0;
            r_axi_wdata   <= '0;
            r_block_we    <= 1'b0;
            r_data_block  <= '0;
            r_miss_count  <= '0;
            r_wb_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_block_we <= 1'b0;
                    r_axi_req  <= 1'b0;
                    if (w_miss) begin
                        r_miss_count <= r_miss_count + CNT_ONE;
                        r_axi_req    <= 1'b1;
                        if (i_dcache_dirty) begin
                            r_axi_addr    <= i_wb_addr & LINE_MASK;
                            r_axi_wdata   <= i_victim_block;
                            r_refill_addr <= i_mem_addr & LINE_MASK;
                            r_axi_we      <= 1'b1;
                            r_state       <= S_WRITEBACK;
                        end else begin
                            r_axi_addr <= i_mem_addr & LINE_MASK;
                            r_axi_we   <= 1'b0;
                            r_state    <= S_REFILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    // req stays high into REFILL so the bus never sees a gap
                    if (i_axi_done) begin
                        r_wb_count <= r_wb_count + CNT_ONE;
                        r_axi_addr <= r_refill_addr;
                        r_axi_we   <= 1'b0;
                        r_state    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (i_axi_done) begin
                        r_data_block <= i_axi_rdata;
                        r_axi_req    <= 1'b0;
                        r_block_we   <= 1'b1;
                        r_state      <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    r_block_we <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_axi_req    = r_axi_req;
    assign o_axi_we     = r_axi_we;
    assign o_axi_addr   = r_axi_addr;
    assign o_axi_wdata  = r_axi_wdata;
    assign o_block_we   = r_block_we;
    assign o_data_block = r_data_block;
    assign o_miss_count = r_miss_count;
    assign o_wb_count   = r_wb_count;

endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
- Sequences the data-cache miss path of the memory stage.
- On a load/store miss it stalls the pipeline. If the victim line is dirty, it first writes that line back over the AXI-side block interface.
- It then refills the line from memory and pulses the dcache block write-enable with the fetched block. The access replays as a hit on the next cycle.
- Sits between the memory stage (dcache hit/dirty/victim outputs) and the AXI block transfer unit.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- BLOCK_WIDTH, 512, cache line width in bits; line size in bytes is BLOCK_WIDTH/8. Must be a power of two, at least 64.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  asynchronous active-high reset.
- i_mem_access  in  1  memory-stage instruction is a load/store.
- i_dcache_hit  in  1  dcache hit for the current access.
- i_dcache_dirty  in  1  victim line for the current access is dirty.
- i_mem_addr  in  ADDR_WIDTH  access byte address (ALU result).
- i_wb_addr  in  ADDR_WIDTH  victim line address from dcache.
- i_victim_block  in  BLOCK_WIDTH  victim line data from dcache.
- i_axi_done  in  1  one-cycle pulse: current AXI block transaction complete.
- i_axi_rdata  in  BLOCK_WIDTH  fetched line; valid when i_axi_done is high in REFILL.
- o_axi_req  out  1  transaction request, held until done.
- o_axi_we  out  1  1 = write (writeback), 0 = read (refill); valid while o_axi_req is high.
- o_axi_addr  out  ADDR_WIDTH  line-aligned transaction address.
- o_axi_wdata  out  BLOCK_WIDTH  writeback data.
- o_block_we  out  1  dcache block write enable.
- o_data_block  out  BLOCK_WIDTH  refill data to dcache.
- o_stall  out  1  stall fetch through memory stages.
- o_miss_count  out  CNT_WIDTH  misses serviced.
- o_wb_count  out  CNT_WIDTH  writebacks performed.

Behaviour:
- States: IDLE, WRITEBACK, REFILL, ALLOCATE. Reset state is IDLE.
- Reset values: all outputs 0, all internal registers 0. o_stall is 0 at reset because i_mem_access is expected low.
- Reset asserted mid-transaction aborts to IDLE immediately and drops o_axi_req. No resume.
- miss = i_mem_access & ~i_dcache_hit.
- o_stall = miss | (state != IDLE). This is combinational, so the stall appears in the same cycle the miss is seen.
- IDLE, on miss:
  - Increment o_miss_count (wraps modulo 2^CNT_WIDTH).
  - If i_dcache_dirty: latch o_axi_addr = i_wb_addr with the low log2(BLOCK_WIDTH/8) bits cleared; latch o_axi_wdata = i_victim_block; latch the refill address from i_mem_addr, line-aligned; go to WRITEBACK.
  - Else: latch o_axi_addr = i_mem_addr, line-aligned; go to REFILL.
- IDLE with no miss: stay in IDLE; o_axi_req = 0, o_block_we = 0.
- WRITEBACK:
  - o_axi_req = 1, o_axi_we = 1.
  - On i_axi_done: increment o_wb_count; o_axi_addr takes the latched refill address; go to REFILL.
  - o_axi_req stays high across this boundary, so the bus sees req drop for no cycle.
- REFILL:
  - o_axi_req = 1, o_axi_we = 0.
  - On i_axi_done: capture i_axi_rdata into o_data_block; go to ALLOCATE.
- ALLOCATE:
  - o_block_we = 1 for exactly one cycle; o_axi_req = 0; go to IDLE.
  - The next cycle is IDLE with the dcache now hitting, so the stall releases when hit = 1.
- All state/data outputs are registered. Only o_stall is combinational.
- Minimum miss latency:
  - Clean miss: miss cycle + REFILL (≥1) + ALLOCATE = 3 cycles of stall when done arrives in the first REFILL cycle.
  - Dirty miss: add ≥1 WRITEBACK cycle.
- i_axi_done in IDLE or ALLOCATE is ignored and has no state effect.
- Changes on i_mem_access, i_mem_addr, i_dcache_hit or i_dcache_dirty after leaving IDLE are ignored; all needed values are latched at miss entry.
- A miss seen in the IDLE cycle immediately following ALLOCATE starts a new miss sequence. The hit status used is the post-allocate status.
- o_data_block holds its last refill value until the next refill capture.
- o_axi_wdata holds until the next dirty miss.

Test Plan:
- Reset, then a hit with i_mem_access=1, hit=1 -> state stays IDLE, o_stall=0, o_axi_req=0, counters remain 0.
- Clean miss at 0x8000_1234, done after 4 REFILL cycles:
  - o_axi_addr=0x8000_1200, o_axi_we=0, req high for 4 cycles.
  - o_block_we pulses for 1 cycle with the data equal to i_axi_rdata.
  - o_stall spans 6 cycles; o_miss_count=1.
- Dirty miss at 0x100, i_wb_addr=0x4047, victim=pattern A:
  - WRITEBACK with o_axi_addr=0x4040, o_axi_we=1, wdata=A.
  - After done: REFILL at 0x100 with req continuously high.
  - Allocate pulse follows; o_wb_count=1, o_miss_count=1.
- Spurious i_axi_done pulses in IDLE and ALLOCATE -> no state or counter change.
- Assert i_arst during REFILL -> o_axi_req, o_stall, o_block_we and counters go to 0 asynchronously, before the next clock edge.
- Back-to-back misses, the second presented in the cycle after ALLOCATE -> second sequence starts immediately; o_miss_count=2.
